// File: rtl/bin2bcd_seq_if.sv
// Valid/ready handshake bundle for the binary-to-BCD converter.
// master drives operands and result acceptance; slave is the converter.
interface bin2bcd_seq_if #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_W-1:0]      in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_bcd;
  logic                  out_ovf;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_bcd,
    input  out_ovf
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_bcd,
    output out_ovf
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary to packed BCD, saturating to all nines.
// One iteration per clock; fixed BIN_W-cycle latency from accept to result.
module bin2bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  bin2bcd_seq_if.slave   bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W);
  localparam logic [BIN_W-1:0] MAXV  = BIN_W'(10**DIGITS - 1);
  localparam logic [BW-1:0]    NINES = {DIGITS{4'h9}};

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [BIN_W-1:0]  bin;
  logic [BW-1:0]     acc;
  logic [BW-1:0]     adj;
  logic [BW-1:0]     acc_n;
  logic [BW-1:0]     obcd;
  logic              ovf;
  logic              oovf;
  logic [CW-1:0]     cnt;
  logic              last;

  assign last = (cnt == CW'(BIN_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (bus.in_valid)  state_n = SHIFT;
      SHIFT:   if (last)          state_n = DONE;
      DONE:    if (bus.out_ready) state_n = IDLE;
      default:                    state_n = IDLE;
    endcase
  end

  always_comb begin
    adj = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  // Top carry out of the accumulator is dropped; overflow saturates instead.
  assign acc_n = BW'({adj, bin[BIN_W-1]});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin  <= '0;
      acc  <= '0;
      ovf  <= 1'b0;
      cnt  <= '0;
      obcd <= '0;
      oovf <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            bin <= bus.in_data;
            acc <= '0;
            ovf <= (bus.in_data > MAXV);
            cnt <= '0;
          end
        end
        SHIFT: begin
          bin <= bin << 1;
          acc <= acc_n;
          cnt <= cnt + 1'b1;
          if (last) begin
            obcd <= ovf ? NINES : acc_n;
            oovf <= ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_bcd   = obcd;
  assign bus.out_ovf   = oovf;
endmodule
